bsg_axi_mem_responder: RTL and testbench

// AXI4 slave memory model responding to the AXI master side of the DMC DFI-to-AXI bridge.

---
 rtl/bsg_axi_mem_responder_if.sv | 43 ++++
 rtl/bsg_axi_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_bsg_axi_mem_responder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_axi_mem_responder_if.sv
// AXI4 write/read channel bundle between a DMC-side master and the memory responder.
// Handshake-only grouping; clock and reset stay outside as plain ports.
interface bsg_axi_mem_responder_if #(
   parameter int id_width_p   = 6,
   parameter int addr_width_p = 32,
   parameter int data_width_p = 64
);
   logic [id_width_p-1:0]     awid;
   logic [addr_width_p-1:0]   awaddr;
   logic                      awvalid;
   logic                      awready;
   logic [data_width_p-1:0]   wdata;
   logic [data_width_p/8-1:0] wstrb;
   logic                      wlast;
   logic                      wvalid;
   logic                      wready;
   logic [id_width_p-1:0]     bid;
   logic [1:0]                bresp;
   logic                      bvalid;
   logic                      bready;
   logic [id_width_p-1:0]     arid;
   logic [addr_width_p-1:0]   araddr;
   logic                      arvalid;
   logic                      arready;
   logic [id_width_p-1:0]     rid;
   logic [data_width_p-1:0]   rdata;
   logic [1:0]                rresp;
   logic                      rlast;
   logic                      rvalid;
   logic                      rready;

   modport master (
      output awid, awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready,
             arid, araddr, arvalid, rready,
      input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  awid, awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready,
             arid, araddr, arvalid, rready,
      output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/bsg_axi_mem_responder.sv
// AXI4 slave flop-array memory: fixed-length INCR bursts, one outstanding per channel; R beat 1 cycle after AR,
// B after last W beat. Backpressure: B held until bready, R beat held stable until rready; W stalls until AW accepted.
module bsg_axi_mem_responder #(
   parameter int axi_id_width_p   = 6,
   parameter int axi_addr_width_p = 32,
   parameter int axi_data_width_p = 64,
   parameter int axi_burst_len_p  = 4,
   parameter int els_p            = 256
) (
   input logic                    clk_i,
   input logic                    reset_n_i,
   bsg_axi_mem_responder_if.slave axi
);
   localparam int bytes_lp = axi_data_width_p / 8;
   localparam int off_lp   = $clog2(bytes_lp);
   localparam int idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = (axi_burst_len_p > 1) ? $clog2(axi_burst_len_p) : 1;
   localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(axi_burst_len_p - 1);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

   logic [axi_data_width_p-1:0] mem [els_p];

   // Readies stay low until the first edge after reset release.
   logic alive;
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) alive <= 1'b0;
      else            alive <= 1'b1;
   end

   w_state_e                w_state_r, w_state_n;
   logic [axi_id_width_p-1:0] w_id_r;
   logic [idx_w_lp-1:0]     w_idx_r;
   logic [cnt_w_lp-1:0]     w_cnt_r;
   logic                    w_err_r;
   logic                    aw_hs, w_hs, w_last_beat;

   assign w_last_beat = (w_cnt_r == cnt_last_lp);

   always_comb begin
      w_state_n   = w_state_r;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bvalid  = 1'b0;
      aw_hs       = 1'b0;
      w_hs        = 1'b0;
      case (w_state_r)
         W_IDLE: begin
            axi.awready = alive;
            if (alive && axi.awvalid) begin
               aw_hs     = 1'b1;
               w_state_n = W_DATA;
            end
         end
         W_DATA: begin
            axi.wready = 1'b1;
            if (axi.wvalid) begin
               w_hs = 1'b1;
               if (w_last_beat) w_state_n = W_RESP;
            end
         end
         W_RESP: begin
            axi.bvalid = 1'b1;
            if (axi.bready) w_state_n = W_IDLE;
         end
         default: w_state_n = W_IDLE;
      endcase
   end

   assign axi.bid   = w_id_r;
   assign axi.bresp = (w_state_r == W_RESP && w_err_r) ? 2'b10 : 2'b00;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         w_state_r <= W_IDLE;
         w_id_r    <= '0;
         w_idx_r   <= '0;
         w_cnt_r   <= '0;
         w_err_r   <= 1'b0;
      end else begin
         w_state_r <= w_state_n;
         if (aw_hs) begin
            w_id_r  <= axi.awid;
            w_idx_r <= axi.awaddr[off_lp +: idx_w_lp];
            w_cnt_r <= '0;
            w_err_r <= 1'b0;
         end else if (w_hs) begin
            w_idx_r <= w_idx_r + idx_w_lp'(1);
            w_cnt_r <= w_last_beat ? '0 : w_cnt_r + cnt_w_lp'(1);
            // Burst length is fixed by the count; a misplaced wlast only flags an error.
            if (axi.wlast != w_last_beat) w_err_r <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_hs) begin
         for (int b = 0; b < bytes_lp; b++) begin
            if (axi.wstrb[b]) mem[w_idx_r][8*b +: 8] <= axi.wdata[8*b +: 8];
         end
      end
   end

   r_state_e                r_state_r, r_state_n;
   logic [axi_id_width_p-1:0] r_id_r;
   logic [idx_w_lp-1:0]     r_idx_r;
   logic [cnt_w_lp-1:0]     r_cnt_r;
   logic                    ar_hs, r_hs, r_last_beat;

   assign r_last_beat = (r_cnt_r == cnt_last_lp);

   always_comb begin
      r_state_n   = r_state_r;
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
      ar_hs       = 1'b0;
      r_hs        = 1'b0;
      if (r_state_r == R_IDLE) begin
         axi.arready = alive;
         if (alive && axi.arvalid) begin
            ar_hs     = 1'b1;
            r_state_n = R_DATA;
         end
      end else begin
         axi.rvalid = 1'b1;
         if (axi.rready) begin
            r_hs = 1'b1;
            if (r_last_beat) r_state_n = R_IDLE;
         end
      end
   end

   // Combinational read sees the pre-write value when a write hits the same word this cycle.
   assign axi.rid   = r_id_r;
   assign axi.rdata = mem[r_idx_r];
   assign axi.rlast = (r_state_r == R_DATA) && r_last_beat;
   assign axi.rresp = 2'b00;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state_r <= R_IDLE;
         r_id_r    <= '0;
         r_idx_r   <= '0;
         r_cnt_r   <= '0;
      end else begin
         r_state_r <= r_state_n;
         if (ar_hs) begin
            r_id_r  <= axi.arid;
            r_idx_r <= axi.araddr[off_lp +: idx_w_lp];
            r_cnt_r <= '0;
         end else if (r_hs) begin
            r_idx_r <= r_idx_r + idx_w_lp'(1);
            r_cnt_r <= r_last_beat ? '0 : r_cnt_r + cnt_w_lp'(1);
         end
      end
   end

   // Address bits outside the word index alias and are deliberately ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{axi.awaddr, axi.araddr};
endmodule

// File: tb/tb_bsg_axi_mem_responder.sv
// Directed bench: stimulus pushes expected B/R responses into queues, a negedge monitor pops and compares.
module tb_bsg_axi_mem_responder;
   localparam int IDW = 6;
   localparam int AW  = 32;
   localparam int DW  = 64;
   localparam int BL  = 4;

   typedef logic [DW-1:0] beats_t [BL];
   typedef logic [7:0]    strbs_t [BL];
   typedef struct packed { logic [IDW-1:0] id; logic [1:0] resp; } b_exp_t;
   typedef struct packed { logic [IDW-1:0] id; logic [DW-1:0] data; logic last; } r_exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   bsg_axi_mem_responder_if #(.id_width_p(IDW), .addr_width_p(AW), .data_width_p(DW)) axi ();

   bsg_axi_mem_responder #(
      .axi_id_width_p(IDW), .axi_addr_width_p(AW), .axi_data_width_p(DW),
      .axi_burst_len_p(BL), .els_p(256)
   ) dut (
      .clk_i(clk),
      .reset_n_i(reset_n),
      .axi(axi)
   );

   initial forever #5 clk = ~clk;

   int     n_vec = 0;
   int     n_err = 0;
   b_exp_t bq[$];
   r_exp_t rq[$];
   bit     rr_rand = 1'b0;
   bit     rr_en   = 1'b0;
   strbs_t s_full;
   strbs_t s_low0;

   logic   r_hold, b_hold;
   r_exp_t r_prev, r_got, r_want;
   b_exp_t b_prev, b_got, b_want;

   task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   // Monitor: scoreboard pops on every handshake, plus hold-stability of stalled beats.
   initial begin
      r_hold = 1'b0;
      b_hold = 1'b0;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            r_got = {axi.rid, axi.rdata, axi.rlast};
            b_got = {axi.bid, axi.bresp};
            if (r_hold) begin
               n_vec++;
               if (!axi.rvalid || r_got !== r_prev) begin
                  n_err++;
                  $display("FAIL r_stable: got v=%b %h want v=1 %h", axi.rvalid, r_got, r_prev);
               end
            end
            if (b_hold) begin
               n_vec++;
               if (!axi.bvalid || b_got !== b_prev) begin
                  n_err++;
                  $display("FAIL b_stable: got v=%b %h want v=1 %h", axi.bvalid, b_got, b_prev);
               end
            end
            if (axi.rvalid && axi.rready) begin
               n_vec++;
               if (rq.size() == 0) begin
                  n_err++;
                  $display("FAIL r_unexpected: got %h want no beat", r_got);
               end else begin
                  r_want = rq.pop_front();
                  if (r_got !== r_want) begin
                     n_err++;
                     $display("FAIL r_beat: got id=%0d data=%h last=%b want id=%0d data=%h last=%b",
                              r_got.id, r_got.data, r_got.last, r_want.id, r_want.data, r_want.last);
                  end
               end
            end
            if (axi.bvalid && axi.bready) begin
               n_vec++;
               if (bq.size() == 0) begin
                  n_err++;
                  $display("FAIL b_unexpected: got %h want no response", b_got);
               end else begin
                  b_want = bq.pop_front();
                  if (b_got !== b_want) begin
                     n_err++;
                     $display("FAIL b_resp: got id=%0d resp=%b want id=%0d resp=%b",
                              b_got.id, b_got.resp, b_want.id, b_want.resp);
                  end
               end
            end
            r_hold = axi.rvalid && !axi.rready;
            r_prev = r_got;
            b_hold = axi.bvalid && !axi.bready;
            b_prev = b_got;
         end
      end
   end

   initial begin
      axi.rready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         axi.rready = rr_rand ? 1'($urandom_range(0, 1)) : rr_en;
      end
   end

   task automatic wait_hs(input int which, input string nm);
      bit ok;
      int n;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 100) begin
         @(negedge clk);
         case (which)
            0:       ok = axi.awready;
            1:       ok = axi.wready;
            default: ok = axi.arready;
         endcase
         @(posedge clk);
         #1;
         n++;
      end
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s_timeout: ready=0 after %0d cycles want ready=1", nm, n);
      end
   endtask

   task automatic wait_drain(input int which);
      int n;
      n = 0;
      while (((which == 0) ? bq.size() : rq.size()) != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      n_vec++;
      if (((which == 0) ? bq.size() : rq.size()) != 0) begin
         n_err++;
         $display("FAIL %s_drain: %0d responses outstanding want 0", (which == 0) ? "b" : "r",
                  (which == 0) ? bq.size() : rq.size());
      end
   endtask

   task automatic wr_burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input beats_t d,
                           input strbs_t s, input int last_at, input logic [1:0] resp, input bit wait_b);
      bq.push_back({id, resp});
      axi.awid    = id;
      axi.awaddr  = addr;
      axi.awvalid = 1'b1;
      wait_hs(0, "aw");
      axi.awvalid = 1'b0;
      for (int i = 0; i < BL; i++) begin
         axi.wdata  = d[i];
         axi.wstrb  = s[i];
         axi.wlast  = (i == last_at);
         axi.wvalid = 1'b1;
         wait_hs(1, "w");
      end
      axi.wvalid = 1'b0;
      axi.wlast  = 1'b0;
      if (wait_b) wait_drain(0);
   endtask

   task automatic rd_burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input beats_t e);
      for (int i = 0; i < BL; i++) rq.push_back({id, e[i], (i == BL - 1)});
      axi.arid    = id;
      axi.araddr  = addr;
      axi.arvalid = 1'b1;
      wait_hs(2, "ar");
      axi.arvalid = 1'b0;
      wait_drain(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      s_full = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      s_low0 = '{8'h0F, 8'h00, 8'h00, 8'h00};
      axi.awid = '0;  axi.awaddr = '0; axi.awvalid = 1'b0;
      axi.wdata = '0; axi.wstrb = '0;  axi.wlast = 1'b0; axi.wvalid = 1'b0;
      axi.bready = 1'b0;
      axi.arid = '0;  axi.araddr = '0; axi.arvalid = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", 64'(axi.awready), 64'd0);
      chk("rst_wready",  64'(axi.wready),  64'd0);
      chk("rst_bvalid",  64'(axi.bvalid),  64'd0);
      chk("rst_arready", 64'(axi.arready), 64'd0);
      chk("rst_rvalid",  64'(axi.rvalid),  64'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_awready", 64'(axi.awready), 64'd1);
      chk("post_arready", 64'(axi.arready), 64'd1);
      chk("post_bid_bresp", 64'({axi.bid, axi.bresp}), 64'd0);
      axi.bready = 1'b1;
      rr_en      = 1'b1;

      // W presented before AW must stall.
      axi.wvalid = 1'b1;
      axi.wdata  = 64'h99;
      axi.wstrb  = 8'hFF;
      repeat (3) begin
         @(negedge clk);
         chk("w_before_aw", 64'(axi.wready), 64'd0);
      end
      @(posedge clk);
      #1;
      wr_burst(6'd3, 32'h40, '{64'h11, 64'h22, 64'h33, 64'h44}, s_full, 3, 2'b00, 1'b1);
      rd_burst(6'd5, 32'h40, '{64'h11, 64'h22, 64'h33, 64'h44});

      wr_burst(6'd1, 32'h100, '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF,
                                64'hFFFFFFFF_FFFFFFFF}, s_full, 3, 2'b00, 1'b1);
      wr_burst(6'd2, 32'h100, '{64'hAAAAAAAA_BBBBBBBB, 64'h0, 64'h0, 64'h0}, s_low0, 3, 2'b00, 1'b1);
      rd_burst(6'd9, 32'h100, '{64'hFFFFFFFF_BBBBBBBB, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF,
                                64'hFFFFFFFF_FFFFFFFF});

      wr_burst(6'd4, 32'h0,   '{64'hB0, 64'hB1, 64'hB2, 64'hB3}, s_full, 3, 2'b00, 1'b1);
      wr_burst(6'd5, 32'h7F0, '{64'hA0, 64'hA1, 64'hA2, 64'hA3}, s_full, 3, 2'b00, 1'b1);
      rd_burst(6'd10, 32'hFF3, '{64'hA0, 64'hA1, 64'hA2, 64'hA3});
      rd_burst(6'd11, 32'h0,   '{64'hA2, 64'hA3, 64'hB2, 64'hB3});

      wr_burst(6'd7, 32'h200, '{64'hC0, 64'hC1, 64'hC2, 64'hC3}, s_full, 1, 2'b10, 1'b1);
      rd_burst(6'd12, 32'h200, '{64'hC0, 64'hC1, 64'hC2, 64'hC3});
      wr_burst(6'd8, 32'h200, '{64'hD0, 64'hD1, 64'hD2, 64'hD3}, s_full, 3, 2'b00, 1'b1);

      // Concurrent AW/AR with B and R both backpressured.
      axi.bready = 1'b0;
      rr_rand    = 1'b1;
      fork
         wr_burst(6'd6, 32'h300, '{64'hE0, 64'hE1, 64'hE2, 64'hE3}, s_full, 3, 2'b00, 1'b0);
         rd_burst(6'd13, 32'h40, '{64'h11, 64'h22, 64'h33, 64'h44});
      join
      repeat (5) begin
         @(negedge clk);
         chk("b_held", 64'(axi.bvalid), 64'd1);
      end
      @(posedge clk);
      #1 axi.bready = 1'b1;
      wait_drain(0);
      rd_burst(6'd14, 32'h300, '{64'hE0, 64'hE1, 64'hE2, 64'hE3});
      rr_rand = 1'b0;
      rd_burst(6'd15, 32'h200, '{64'hD0, 64'hD1, 64'hD2, 64'hD3});

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
